// File: rtl/au_issue_ctrl.sv
// Purpose: initiator for the arithmetic unit; takes one command at a time, pulses
//          au_start with stable operands, waits for au_done (timeout-guarded) and
//          returns the result on a valid/ready response channel.
// Latency: command accept -> au_start 1 cycle; au_done -> rsp_valid 1 cycle.
// Backpressure: cmd_ready only in IDLE (one op outstanding); rsp_* held until rsp_ready.
// Ports: cmd_* request in, au_* to/from the AU, rsp_* response out, op_count = delivered responses.
module au_issue_ctrl #(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [1:0]       cmd_op,
  output logic [WIDTH-1:0] au_a,
  output logic [WIDTH-1:0] au_b,
  output logic [1:0]       au_op,
  output logic             au_start,
  input  logic             au_done,
  input  logic [WIDTH-1:0] au_s,
  input  logic [WIDTH-1:0] au_hi,
  input  logic [WIDTH-1:0] au_lo,
  input  logic             au_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_hi,
  output logic [WIDTH-1:0] rsp_lo,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [CNT_W-1:0] op_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LIM = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state_q;
  logic [TW-1:0]    tmo_q;
  logic [TW-1:0]    tmo_d;
  logic [WIDTH-1:0] au_a_q, au_b_q;
  logic [1:0]       au_op_q;
  logic             au_start_q;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_hi_q, rsp_lo_q;
  logic             rsp_zero_q, rsp_err_q;
  logic [CNT_W-1:0] op_count_q;

  assign tmo_d = tmo_q + TW'(1);

  // Gated with rst_n so the requester sees no ready while reset is held.
  assign cmd_ready = rst_n & (state_q == IDLE);

  assign au_a      = au_a_q;
  assign au_b      = au_b_q;
  assign au_op     = au_op_q;
  assign au_start  = au_start_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_hi    = rsp_hi_q;
  assign rsp_lo    = rsp_lo_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_err   = rsp_err_q;
  assign op_count  = op_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tmo_q       <= '0;
      au_a_q      <= '0;
      au_b_q      <= '0;
      au_op_q     <= '0;
      au_start_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_hi_q    <= '0;
      rsp_lo_q    <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      op_count_q  <= '0;
    end else begin
      au_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            au_a_q  <= cmd_a;
            au_b_q  <= cmd_b;
            au_op_q <= cmd_op;
            if (cmd_op == 2'b11 && cmd_b == '0) begin
              // Divide by zero is answered locally; the AU is never started.
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_hi_q    <= cmd_a;
              rsp_lo_q    <= '1;
              rsp_zero_q  <= 1'b0;
              state_q     <= RESP;
            end else begin
              au_start_q <= 1'b1;
              state_q    <= ISSUE;
            end
          end
        end
        ISSUE: begin
          tmo_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          // au_done is checked before the limit so a done on the last cycle wins.
          if (au_done) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_zero_q  <= au_zero;
            if (au_op_q[1]) begin
              rsp_hi_q <= au_hi;
              rsp_lo_q <= au_lo;
            end else begin
              rsp_hi_q <= '0;
              rsp_lo_q <= au_s;
            end
            state_q <= RESP;
          end else begin
            tmo_q <= tmo_d;
            if (tmo_d == TMO_LIM) begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_hi_q    <= '0;
              rsp_lo_q    <= '0;
              rsp_zero_q  <= 1'b0;
              state_q     <= RESP;
            end
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            op_count_q  <= op_count_q + CNT_W'(1);
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_au_issue_ctrl.sv
module tb_au_issue_ctrl;
  localparam int W  = 32;
  localparam int TO = 64;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          cmd_valid, cmd_ready;
  logic [W-1:0]  cmd_a, cmd_b;
  logic [1:0]    cmd_op;
  logic [W-1:0]  au_a, au_b;
  logic [1:0]    au_op;
  logic          au_start;
  wire           au_done;
  logic          model_done, stray_done;
  logic [W-1:0]  au_s, au_hi, au_lo;
  logic          au_zero;
  logic          rsp_valid, rsp_ready;
  logic [W-1:0]  rsp_hi, rsp_lo;
  logic          rsp_zero, rsp_err;
  logic [CW-1:0] op_count;

  assign au_done = model_done | stray_done;

  au_issue_ctrl #(.WIDTH(W), .TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .au_a(au_a), .au_b(au_b), .au_op(au_op), .au_start(au_start),
    .au_done(au_done), .au_s(au_s), .au_hi(au_hi), .au_lo(au_lo), .au_zero(au_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_hi(rsp_hi), .rsp_lo(rsp_lo), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .op_count(op_count)
  );

  int total = 0;
  int bad = 0;
  int start_cnt = 0;
  int au_delay = -1;   // AU completion delay in cycles after au_start; <1 means never
  int exp_count = 0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         zero;
    logic         err;
    int           lat;   // cycles from accept edge until rsp_valid is seen
  } exp_t;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Plain arithmetic meaning of each opcode: {high, low} of the full result.
  function automatic logic [2*W-1:0] arith(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [1:0] op);
    logic [2*W-1:0] wa, wb;
    wa = {{W{1'b0}}, a};
    wb = {{W{1'b0}}, b};
    case (op)
      2'd0:    arith = {{W{1'b0}}, a + b};
      2'd1:    arith = {{W{1'b0}}, a - b};
      2'd2:    arith = wa * wb;
      default: arith = {a % b, a / b};
    endcase
  endfunction

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [1:0] op, input int delay);
    exp_t e;
    logic [2*W-1:0] r;
    e.hi = '0; e.lo = '0; e.zero = 1'b0; e.err = 1'b0; e.lat = 0;
    if (op == 2'd3 && b == 0) begin
      e.err = 1'b1; e.hi = a; e.lo = '1; e.lat = 0;
    end else if (delay < 1 || delay > TO) begin
      e.err = 1'b1; e.lat = TO + 1;
    end else begin
      r = arith(a, b, op);
      e.hi = r[2*W-1:W];
      e.lo = r[W-1:0];
      e.zero = (r == 0);
      e.lat = delay + 1;
    end
    return e;
  endfunction

  always @(negedge clk) if (au_start === 1'b1) start_cnt++;

  // AU model: answers au_delay cycles after the start pulse, with junk on the
  // result bus that the selected opcode should not use.
  initial begin : au_model
    logic [W-1:0] ma, mb;
    logic [1:0] mop;
    logic [2*W-1:0] r;
    model_done = 1'b0; au_s = '0; au_hi = '0; au_lo = '0; au_zero = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (rst_n === 1'b1 && au_start === 1'b1 && au_delay > 0) begin
        ma = au_a; mb = au_b; mop = au_op;
        repeat (au_delay) @(posedge clk);
        #1;
        check("au_operands_held", {au_a, au_b, au_op}, {ma, mb, mop});
        r = arith(ma, mb, mop);
        if (mop[1]) begin
          au_s = $urandom; au_hi = r[2*W-1:W]; au_lo = r[W-1:0];
        end else begin
          au_s = r[W-1:0]; au_hi = $urandom; au_lo = $urandom;
        end
        au_zero = (r == 0);
        model_done = 1'b1;
        @(posedge clk); #1;
        model_done = 1'b0;
      end
    end
  end

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                       input int delay, input int hold, input bit stray);
    exp_t e;
    int s0, n, viol;
    e = model(a, b, op, delay);
    au_delay = delay;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    check("cmd_ready_idle", cmd_ready, 1'b1);
    s0 = start_cnt;
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_a = $urandom; cmd_b = $urandom; cmd_op = 2'($urandom);
    n = 0; viol = 0;
    while (rsp_valid !== 1'b1 && n < 200) begin
      if (cmd_ready !== 1'b0) viol++;
      n++;
      @(posedge clk); #1;
    end
    check("latency", n, e.lat);
    check("cmd_ready_low_busy", viol, 0);
    check("rsp_hi", rsp_hi, e.hi);
    check("rsp_lo", rsp_lo, e.lo);
    check("rsp_zero", rsp_zero, e.zero);
    check("rsp_err", rsp_err, e.err);
    check("start_pulses", start_cnt - s0, (e.lat == 0) ? 0 : 1);
    viol = 0;
    for (int i = 0; i < hold; i++) begin
      if (stray && i == 0) stray_done = 1'b1;
      @(posedge clk); #1;
      stray_done = 1'b0;
      if ({rsp_valid, rsp_hi, rsp_lo, rsp_zero, rsp_err, cmd_ready} !==
          {1'b1, e.hi, e.lo, e.zero, e.err, 1'b0}) viol++;
    end
    if (hold > 0) check("rsp_held", viol, 0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    exp_count++;
    check("op_count", op_count, exp_count[CW-1:0]);
    check("rsp_valid_drop", rsp_valid, 1'b0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [1:0] rop;
    int rd;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0;
    rsp_ready = 1'b0; stray_done = 1'b0;
    #12;
    check("reset_au", {au_start, au_a, au_b, au_op}, '0);
    check("reset_rsp", {rsp_valid, rsp_hi, rsp_lo, rsp_zero, rsp_err, op_count, cmd_ready}, '0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_ready", cmd_ready, 1'b1);

    // Directed cases
    do_op(32'd5, 32'hFFFF_FFFB, 2'b00, 2, 0, 1'b0);      // add to zero
    do_op(32'h1_0000, 32'h1_0000, 2'b10, 33, 0, 1'b0);   // mult, hi=1 lo=0
    do_op(32'h1234, 32'd0, 2'b11, 5, 0, 1'b0);           // divide by zero
    do_op(32'd77, 32'd3, 2'b01, -1, 0, 1'b0);            // timeout
    do_op(32'd1000, 32'd7, 2'b11, TO, 0, 1'b0);          // done on last cycle wins
    do_op(32'd9, 32'd4, 2'b01, 1, 10, 1'b1);             // backpressure + stray done

    // Reset during a divide in WAIT
    au_delay = -1;
    cmd_valid = 1'b1; cmd_a = 32'd100; cmd_b = 32'd7; cmd_op = 2'b11;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_au", {au_start, au_a, au_b, au_op}, '0);
    check("midreset_rsp", {rsp_valid, rsp_hi, rsp_lo, rsp_zero, rsp_err, op_count, cmd_ready}, '0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    exp_count = 0;
    do_op(32'd20, 32'd22, 2'b00, 3, 0, 1'b0);

    // Randomized traffic
    for (int k = 0; k < 25; k++) begin
      ra = $urandom;
      rop = 2'($urandom_range(0, 3));
      rb = ($urandom_range(0, 4) == 0) ? '0 : $urandom;
      if ($urandom_range(0, 2) == 0) rb = W'($urandom_range(1, 9));
      rd = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(1, TO));
      do_op(ra, rb, rop, rd, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/au_issue_ctrl.md
Name: au_issue_ctrl

Overview:
- Initiator side of the arithmetic-unit interface.
- Accepts arithmetic commands from an upstream requester over a valid/ready handshake and issues each one to the AU as a single start pulse with stable operands.
- Waits for the AU's multi-cycle completion, with a timeout guard, then returns the result over a valid/ready response channel.
- Sits between the datapath control and the AU so that add/sub/mult/div latency is hidden behind one uniform handshake.

Parameters:
- WIDTH, 32, operand and result width.
- TIMEOUT_CYCLES, 64, maximum WAIT cycles before an op is aborted with an error.
- CNT_W, 16, width of the completed-op counter.

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
cmd_a  in  WIDTH  operand a
cmd_b  in  WIDTH  operand b
cmd_op  in  2  00 add, 01 sub, 10 mult, 11 div
au_a  out  WIDTH  operand a to AU
au_b  out  WIDTH  operand b to AU
au_op  out  2  ALUop to AU
au_start  out  1  one-cycle launch pulse
au_done  in  1  AU result valid, single-cycle pulse
au_s  in  WIDTH  add/sub result
au_hi  in  WIDTH  product high / remainder
au_lo  in  WIDTH  product low / quotient
au_zero  in  1  AU zero flag
rsp_valid  out  1  response present
rsp_ready  in  1  requester takes response
rsp_hi  out  WIDTH  high result
rsp_lo  out  WIDTH  low result
rsp_zero  out  1  zero flag
rsp_err  out  1  timeout or divide-by-zero
op_count  out  CNT_W  responses delivered, wraps

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - cmd_ready=0 while rst_n=0, then 1 in IDLE.
  - au_start=0; au_a, au_b, au_op = 0.
  - rsp_valid=0; rsp_hi, rsp_lo, rsp_zero, rsp_err = 0.
  - op_count=0; timeout counter=0.
  - Reset asserted mid-operation abandons the op silently; no response is produced.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, capture a, b, op into au_a/au_b/au_op.
  - If op==11 and cmd_b==0, go to RESP with rsp_err=1, rsp_hi=cmd_a, rsp_lo=all ones, rsp_zero=0. No au_start is issued.
  - Otherwise go to ISSUE.
- ISSUE:
  - au_start=1 for exactly this cycle.
  - Go to WAIT; clear the timeout counter.
- WAIT:
  - au_a/au_b/au_op are held stable from ISSUE until leaving WAIT.
  - au_done is sampled starting the cycle after au_start.
  - On au_done, capture results and go to RESP with rsp_err=0:
    - op 00/01: rsp_lo=au_s, rsp_hi=0.
    - op 10/11: rsp_hi=au_hi, rsp_lo=au_lo.
    - rsp_zero=au_zero in both cases.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT_CYCLES, go to RESP with rsp_err=1, rsp_hi=0, rsp_lo=0, rsp_zero=0.
  - If au_done arrives in the same cycle the counter reaches the limit, au_done wins: normal result, no error.
- RESP:
  - rsp_valid=1; rsp_* held stable until rsp_ready.
  - On rsp_valid&&rsp_ready, increment op_count (wrapping at 2^CNT_W) and go to IDLE.
  - cmd_ready=0 in every state except IDLE, so there is at most one op outstanding.
- au_done pulses arriving in IDLE, ISSUE or RESP are ignored.
- Accept-to-au_start latency: 1 cycle. au_done-to-rsp_valid latency: 1 cycle.
- Minimum command-to-command spacing: 4 cycles (AU done immediately, rsp_ready held high).

Test Plan:
- Add: a=5, b=0xFFFFFFFB, op=00; AU model returns au_s=0, au_zero=1 two cycles after au_start -> rsp_lo=0, rsp_hi=0, rsp_zero=1, rsp_err=0, op_count=1.
- Mult: a=0x10000, b=0x10000, op=10; AU done after 33 cycles with hi=1, lo=0 -> rsp_hi=1, rsp_lo=0, exactly one au_start pulse, cmd_ready low throughout.
- Divide by zero: a=0x1234, b=0, op=11 -> no au_start; rsp_err=1, rsp_hi=0x1234, rsp_lo=0xFFFFFFFF.
- Timeout: AU model never asserts au_done -> rsp_valid exactly TIMEOUT_CYCLES=64 WAIT cycles after au_start, rsp_err=1, hi/lo=0.
- Backpressure plus stray done: hold rsp_ready=0 for 10 cycles and inject an extra au_done in RESP -> rsp_* unchanged, no new command accepted, op_count increments once when rsp_ready=1.
- Reset mid-WAIT: assert rst_n=0 during a div -> all outputs 0 immediately; after release, a new add completes normally with op_count=1.
